// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input and received-byte outputs of the UART receiver.
interface uart_rx_if #(
    parameter int NB_DATA = 8
);
    logic               i_rx;
    logic [NB_DATA-1:0] o_rx_data;
    logic               o_rx_done;
    logic               o_frame_err;

    modport master (input i_rx, output o_rx_data, o_rx_done, o_frame_err);
    modport slave (output i_rx, input o_rx_data, o_rx_done, o_frame_err);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver, LSB first, one-cycle done strobe.
module uart_rx #(
    parameter int NB_DATA  = 8,
    parameter int SB_TICK  = 16,
    parameter int BAUD_DIV = 163
) (
    input logic        i_clock,
    input logic        i_reset,
    uart_rx_if.master  bus
);
    localparam int NW = NB_DATA > 1 ? $clog2(NB_DATA) : 1;
    localparam int BW = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync2_q;
    logic [BW-1:0]      baud_q, baud_d;
    logic [3:0]         s_q, s_d;
    logic [NW-1:0]      n_q, n_d;
    logic [NB_DATA-1:0] sh_q, sh_d, data_q, data_d;
    logic               done_q, done_d, ferr_q, ferr_d;
    logic               rx, tick;

    assign rx   = sync2_q;
    assign tick = baud_q == BW'(BAUD_DIV - 1);

    always_comb begin
        baud_d  = tick ? '0 : baud_q + BW'(1);
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        sh_d    = sh_q;
        data_d  = data_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (!rx) begin
                state_d = START;
                s_d     = '0;
            end
            START: if (tick) begin
                s_d = s_q + 4'd1;
                if (s_q == 4'd7) begin
                    // a start bit that is high again at its centre was noise
                    state_d = rx ? IDLE : DATA;
                    s_d     = '0;
                    n_d     = '0;
                end
            end
            DATA: if (tick) begin
                s_d = s_q + 4'd1;
                if (s_q == 4'd15) begin
                    s_d     = '0;
                    sh_d    = NB_DATA'({rx, sh_q} >> 1);
                    state_d = n_q == NW'(NB_DATA - 1) ? STOP : DATA;
                    n_d     = n_q == NW'(NB_DATA - 1) ? n_q : n_q + NW'(1);
                end
            end
            default: if (tick) begin
                s_d = s_q + 4'd1;
                if (s_q == 4'(SB_TICK - 1)) begin
                    state_d = IDLE;
                    data_d  = sh_q;
                    ferr_d  = !rx;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            baud_q  <= '0;
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= bus.i_rx;
            sync2_q <= sync1_q;
            baud_q  <= baud_d;
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.o_rx_data   = data_q;
    assign bus.o_rx_done   = done_q;
    assign bus.o_frame_err = ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames against a queue-based scoreboard.
module tb_uart_rx;
    localparam int BIT = 64;

    logic i_clock = 1'b0;
    logic i_reset = 1'b1;
    int   tests   = 0;
    int   fails   = 0;
    logic prev_done = 1'b0;
    logic [8:0] exp_q[$];
    logic [8:0] e;

    uart_rx_if #(.NB_DATA(8)) u_if ();

    uart_rx #(.NB_DATA(8), .SB_TICK(16), .BAUD_DIV(4)) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (u_if.master)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a frame carries its byte unchanged, frame_err is the inverse of the stop level.
    // A bad stop bit is held low only long enough to cover the stop sample.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        exp_q.push_back({~stop, b});
        for (int i = 0; i < 10; i++) begin
            u_if.i_rx = f[i];
            repeat ((i == 9 && !stop) ? 40 : BIT) @(negedge i_clock);
        end
        u_if.i_rx = 1'b1;
        repeat (gap) @(negedge i_clock);
    endtask

    always @(negedge i_clock) begin
        if (u_if.o_rx_done) begin
            check("done_one_cycle", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: got data %0h with no frame pending", u_if.o_rx_data);
            end else begin
                e = exp_q.pop_front();
                check("rx_data", {24'd0, u_if.o_rx_data}, {24'd0, e[7:0]});
                check("frame_err", {31'd0, u_if.o_frame_err}, {31'd0, e[8]});
            end
        end
        prev_done = u_if.o_rx_done;
    end

    initial begin
        logic [9:0] f;
        logic [7:0] b;
        logic       stop;
        u_if.i_rx = 1'b1;
        repeat (5) @(negedge i_clock);
        check("rst_data", {24'd0, u_if.o_rx_data}, 32'd0);
        check("rst_done", {31'd0, u_if.o_rx_done}, 32'd0);
        check("rst_ferr", {31'd0, u_if.o_frame_err}, 32'd0);
        i_reset = 1'b0;
        repeat (3 * BIT) @(negedge i_clock);
        send_frame(8'hA5, 1'b1, BIT);
        u_if.i_rx = 1'b0;
        repeat (16) @(negedge i_clock);
        u_if.i_rx = 1'b1;
        repeat (2 * BIT) @(negedge i_clock);
        send_frame(8'h3C, 1'b1, BIT);
        send_frame(8'h3C, 1'b0, 2 * BIT);
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, BIT);
        f = {1'b1, 8'h81, 1'b0};
        for (int i = 0; i < 5; i++) begin
            u_if.i_rx = f[i];
            repeat (BIT) @(negedge i_clock);
        end
        u_if.i_rx = f[5];
        repeat (BIT / 2) @(negedge i_clock);
        i_reset = 1'b1;
        repeat (4) @(negedge i_clock);
        check("midrst_data", {24'd0, u_if.o_rx_data}, 32'd0);
        check("midrst_done", {31'd0, u_if.o_rx_done}, 32'd0);
        check("midrst_ferr", {31'd0, u_if.o_frame_err}, 32'd0);
        i_reset = 1'b0;
        u_if.i_rx = 1'b1;
        repeat (12 * BIT) @(negedge i_clock);
        send_frame(8'h5A, 1'b1, BIT);
        for (int k = 0; k < 12; k++) begin
            b    = 8'($urandom);
            stop = $urandom_range(0, 3) != 0;
            send_frame(b, stop, stop ? int'($urandom_range(0, 20)) : 2 * BIT + int'($urandom_range(0, 20)));
        end
        for (int i = 0; i < 4 * BIT && exp_q.size() != 0; i++) @(negedge i_clock);
        check("frames_pending", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter NB_DATA, default 8: number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16: number of oversampling ticks in the stop bit.
REQ-003 Parameter BAUD_DIV, default 163: i_clock cycles per oversampling tick (50 MHz / (19200 x 16)).
REQ-004 i_clock  input  1  sole clock; all flops rise-edge on it.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_rx  input  1  serial line; idles high; asynchronous to i_clock.
REQ-007 o_rx_data  output  NB_DATA  last received byte; feeds the debug unit's i_rx_data.
REQ-008 o_rx_done  output  1  one-cycle strobe marking a new o_rx_data; feeds the debug unit's i_rx_done.
REQ-009 o_frame_err  output  1  stop-bit sample of the last frame was 0.

Function
REQ-010 i_rx SHALL pass through a 2-flop synchronizer, with both flops reset to 1, before any use; all references to rx below mean the synchronized value.
REQ-011 Baud generator: a free-running counter SHALL count 0..BAUD_DIV-1 and wrap; tick SHALL be high for exactly one cycle when count == BAUD_DIV-1.
REQ-012 FSM states SHALL be IDLE, START, DATA and STOP; s is a 4-bit tick counter; n is a bit counter of width clog2(NB_DATA).
REQ-013 IDLE: when rx == 0, the block SHALL go to START with s = 0, independent of tick.
REQ-014 START: on each tick, s SHALL increment; on the tick where s == 7 (mid start bit), the block SHALL go to DATA with s = 0, n = 0 if rx == 0, else return to IDLE (glitch reject, no strobe).
REQ-015 DATA: on each tick, s SHALL increment; on the tick where s == 15, the block SHALL shift rx into the shift register MSB (LSB-first reception), set s = 0, and either go to STOP if n == NB_DATA-1 or increment n.
REQ-016 STOP: on each tick, s SHALL increment; on the tick where s == SB_TICK-1, the block SHALL go to IDLE and register the outputs per REQ-017.
REQ-017 Output registration SHALL load o_rx_data from the shift register, set o_frame_err to the inverse of rx, and assert o_rx_done, all in the same cycle.
REQ-018 o_rx_done SHALL be high exactly one i_clock cycle per completed frame, in the cycle after the final stop tick; it SHALL never be high for two consecutive cycles.
REQ-019 o_rx_data and o_frame_err SHALL hold their values until the next completed frame.
REQ-020 A frame with a bad stop bit SHALL still strobe o_rx_done, with o_frame_err = 1.
REQ-021 Back-to-back frames SHALL be received correctly: a start edge is accepted in the first cycle of IDLE after STOP.
REQ-022 Ticks SHALL be ignored in IDLE; the baud counter SHALL NOT be resynchronized to the start edge.
REQ-023 The block SHALL apply no backpressure; the consumer samples on o_rx_done, and a missed strobe is lost.

Reset
REQ-024 On i_reset high, the FSM SHALL go to IDLE and s, n, the shift register and the baud counter SHALL clear to 0.
REQ-025 On i_reset high, o_rx_data SHALL be 0, o_rx_done 0 and o_frame_err 0, and the synchronizer flops SHALL be 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no strobe; the first full frame after release SHALL be received normally.

Verification (BAUD_DIV=4 for simulation; bit period = 64 clocks)
REQ-027 Reset: assert i_reset with i_rx=1 -> o_rx_data=0x00, o_rx_done=0, o_frame_err=0, FSM in IDLE.
REQ-028 Frame 0xA5 with stop=1 -> exactly one o_rx_done pulse, o_rx_data=0xA5, o_frame_err=0.
REQ-029 Low glitch on i_rx of 16 clocks, then high -> no o_rx_done; a following frame 0x3C -> o_rx_data=0x3C.
REQ-030 Frame 0x3C with stop=0 -> one o_rx_done pulse, o_rx_data=0x3C, o_frame_err=1.
REQ-031 Frames 0x00 then 0xFF with no idle gap -> two pulses, with data 0x00 then 0xFF, and o_frame_err=0 on both.
REQ-032 i_reset pulsed during data bit 4 of frame 0x81 -> no strobe, outputs 0; next frame 0x5A -> o_rx_data=0x5A, o_frame_err=0.
